// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module alu_share_arb #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req_a0,
  input  logic [DATA_WIDTH-1:0] req_b0,
  input  logic [DATA_WIDTH-1:0] req_a1,
  input  logic [DATA_WIDTH-1:0] req_b1,
  input  logic [2:0]            req_op0,
  input  logic [2:0]            req_op1,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_carryout,
  output logic                  rsp_zero,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t                state_q;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  ovf_q;
  logic                  co_q;
  logic                  zero_q;
  logic [1:0]            rsp_valid_q;
  logic                  busy_q;

  logic gnt;
  logic req_hs;
  logic rsp_hs;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt = req_valid[1] & ~req_valid[0];
`else
  logic last_grant_q;
  // On a tie the port that did not win last time goes next.
  assign gnt = req_valid[1] &
               (~req_valid[0] | ~last_grant_q);
`endif

  // Gated by resetn so no grant leaks out while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && resetn) begin
      req_ready[1] = req_valid[1] & gnt;
      req_ready[0] = req_valid[0] & ~gnt;
    end
  end

  assign req_hs = |(req_valid & req_ready);
  assign rsp_hs = rsp_valid_q[owner_q] &
                  rsp_ready[owner_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_q         <= '0;
      res_q        <= '0;
      ovf_q        <= 1'b0;
      co_q         <= 1'b0;
      zero_q       <= 1'b0;
      rsp_valid_q  <= 2'b00;
      busy_q       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_hs) begin
            op_a_q  <= gnt ? req_a1 : req_a0;
            op_b_q  <= gnt ? req_b1 : req_b0;
            op_q    <= gnt ? req_op1 : req_op0;
            owner_q <= gnt;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= alu_Result;
          ovf_q       <= alu_Overflow;
          co_q        <= alu_CarryOut;
          zero_q      <= alu_Zero;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid_q  <= 2'b00;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= owner_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_A        = op_a_q;
  assign alu_B        = op_b_q;
  assign alu_ALUop    = op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;
  assign rsp_carryout = co_q;
  assign rsp_zero     = zero_q;
  assign busy         = busy_q;

endmodule
